// File: rtl/operand_net_v_pkg.sv
// Shared defaults and operand path decoding for the per-lane operand network.
// Widths here are only defaults; parameter-sized types (data_t, index_t, netv_sel_t,
// wb_hist_t) are declared inside the modules because they depend on module parameters.
package operand_net_v_pkg;

   localparam int unsigned DefNumLanes = 16;
   localparam int unsigned DefNumSrc   = 3;
   localparam int unsigned DefNumRfp   = 4;
   localparam int unsigned DefNumWb    = 2;
   localparam int unsigned DefWidthData = 32;
   localparam int unsigned DefWidthIdx  = 7;

   // Where a source's final operand comes from
   typedef enum logic [1:0] {
      PathLocal,
      PathScalar,
      PathLane,
      PathLoop
   } path_e;

   // Scalar broadcast beats lane export; a lane select that names this lane loops back
   // to the local operand instead of the externally exported copy.
   function automatic path_e decode_path(input logic scalar_en, input logic lane_en,
                                         input logic lane_self);
      path_e path;
      if (scalar_en) begin
         path = PathScalar;
      end else if (lane_en && lane_self) begin
         path = PathLoop;
      end else if (lane_en) begin
         path = PathLane;
      end else begin
         path = PathLocal;
      end
      return path;
   endfunction

endpackage

// File: rtl/fwd_hist_v.sv
// Writeback history shift register with newest-first forwarding lookup for
// several query indices. The live writeback beats every stored entry.
module fwd_hist_v #(
   parameter int unsigned NUM_WB     = 2,
   parameter int unsigned NUM_SRC    = 3,
   parameter int unsigned WIDTH_DATA = 32,
   parameter int unsigned WIDTH_IDX  = 7
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 wb_valid_i,
   input  logic [WIDTH_IDX-1:0]                 wb_idx_i,
   input  logic [WIDTH_DATA-1:0]                wb_data_i,
   input  logic [NUM_SRC-1:0][WIDTH_IDX-1:0]    query_idx_i,
   output logic [NUM_SRC-1:0]                   hit_o,
   output logic [NUM_SRC-1:0][WIDTH_DATA-1:0]   data_o
);

   typedef struct packed {
      logic                  valid;
      logic [WIDTH_IDX-1:0]  idx;
      logic [WIDTH_DATA-1:0] data;
   } wb_hist_t;

   wb_hist_t [NUM_WB-1:0] hist_q, hist_d;

   // Shift a new writeback into entry 0 and drop the oldest; hold otherwise
   always_comb begin
      hist_d = hist_q;
      if (wb_valid_i) begin
         hist_d[0].valid = 1'b1;
         hist_d[0].idx   = wb_idx_i;
         hist_d[0].data  = wb_data_i;
         for (int i = 1; i < int'(NUM_WB); i++) begin
            hist_d[i] = hist_q[i-1];
         end
      end
   end

   // History register; only valid bits matter after reset but clearing all is harmless
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hist_q <= '0;
      end else begin
         hist_q <= hist_d;
      end
   end

   // Walk oldest to newest so the newest match is the one left standing
   always_comb begin
      hit_o  = '0;
      data_o = '0;
      for (int q = 0; q < int'(NUM_SRC); q++) begin
         for (int i = int'(NUM_WB) - 1; i >= 0; i--) begin
            if (hist_q[i].valid && (hist_q[i].idx == query_idx_i[q])) begin
               hit_o[q]  = 1'b1;
               data_o[q] = hist_q[i].data;
            end
         end
         if (wb_valid_i && (wb_idx_i == query_idx_i[q])) begin
            hit_o[q]  = 1'b1;
            data_o[q] = wb_data_i;
         end
      end
   end

endmodule

// File: rtl/operand_net_v.sv
// Per-lane operand network: read-port select, writeback forwarding, scalar/lane
// substitution, and a stallable one-cycle output register.
module operand_net_v
   import operand_net_v_pkg::*;
#(
   parameter int unsigned NUM_LANES   = DefNumLanes,
   parameter int unsigned LANE_ID     = 0,
   parameter int unsigned NUM_SRC     = DefNumSrc,
   parameter int unsigned NUM_RFP     = DefNumRfp,
   parameter int unsigned NUM_WB      = DefNumWb,
   parameter int unsigned WIDTH_DATA  = DefWidthData,
   parameter int unsigned WIDTH_IDX   = DefWidthIdx,
   parameter int unsigned WIDTH_LANES = $clog2(NUM_LANES),
   parameter int unsigned WIDTH_RFP   = $clog2(NUM_RFP),
   parameter int unsigned WIDTH_F     = WIDTH_RFP + 2 + WIDTH_LANES
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic                                  I_Req,
   input  logic                                  I_Stall,
   input  logic [NUM_SRC*WIDTH_F-1:0]            I_Sel_Path,
   input  logic [NUM_SRC-1:0]                    I_Sel_ALU_Src,
   input  logic [WIDTH_DATA-1:0]                 I_Scalar_Data,
   input  logic [NUM_RFP*WIDTH_DATA-1:0]         I_Src_Data,
   input  logic [NUM_RFP*WIDTH_IDX-1:0]          I_Src_Idx,
   input  logic                                  I_WB_Valid,
   input  logic [WIDTH_IDX-1:0]                  I_WB_DstIdx,
   input  logic [WIDTH_DATA-1:0]                 I_WB_Data,
   input  logic [NUM_SRC*NUM_LANES*WIDTH_DATA-1:0] I_Lane_Data,
   output logic                                  O_Valid,
   output logic [NUM_SRC*WIDTH_DATA-1:0]         O_Src_Data,
   output logic [NUM_SRC*WIDTH_DATA-1:0]         O_Lane_Data
);

   typedef logic [WIDTH_DATA-1:0] data_t;
   typedef logic [WIDTH_IDX-1:0]  index_t;

   // Field layout, LSB first: rfp_sel, scalar_en, lane_en, lane_idx
   typedef struct packed {
      logic [WIDTH_LANES-1:0] lane_idx;
      logic                   lane_en;
      logic                   scalar_en;
      logic [WIDTH_RFP-1:0]   rfp_sel;
   } netv_sel_t;

   netv_sel_t                sel     [NUM_SRC];
   logic     [NUM_SRC-1:0]   active;
   data_t    [NUM_SRC-1:0]   rf_data;
   index_t   [NUM_SRC-1:0]   rf_idx;
   logic     [NUM_SRC-1:0]   fwd_hit;
   data_t    [NUM_SRC-1:0]   fwd_data;
   data_t    [NUM_SRC-1:0]   local_op;
   data_t    [NUM_SRC-1:0]   final_op;

   logic                     valid_q, valid_d;
   data_t    [NUM_SRC-1:0]   src_q, src_d;
   data_t    [NUM_SRC-1:0]   lane_q, lane_d;

   // Decode per-source selects and fetch the raw register-file operand
   always_comb begin
      for (int s = 0; s < int'(NUM_SRC); s++) begin
         sel[s]     = netv_sel_t'(I_Sel_Path[s*WIDTH_F +: WIDTH_F]);
         active[s]  = I_Req & I_Sel_ALU_Src[s];
         rf_data[s] = '0;
         rf_idx[s]  = '0;
         // Non-power-of-two port counts leave unused encodings; they read as zero
         if (int'(sel[s].rfp_sel) < int'(NUM_RFP)) begin
            rf_data[s] = I_Src_Data[int'(sel[s].rfp_sel)*WIDTH_DATA +: WIDTH_DATA];
            rf_idx[s]  = I_Src_Idx[int'(sel[s].rfp_sel)*WIDTH_IDX +: WIDTH_IDX];
         end
      end
   end

   fwd_hist_v #(
      .NUM_WB     (NUM_WB),
      .NUM_SRC    (NUM_SRC),
      .WIDTH_DATA (WIDTH_DATA),
      .WIDTH_IDX  (WIDTH_IDX)
   ) u_fwd_hist (
      .clk_i       (clock),
      .rst_ni      (reset),
      .wb_valid_i  (I_WB_Valid),
      .wb_idx_i    (I_WB_DstIdx),
      .wb_data_i   (I_WB_Data),
      .query_idx_i (rf_idx),
      .hit_o       (fwd_hit),
      .data_o      (fwd_data)
   );

   // Apply forwarding, then scalar/lane substitution; inactive sources drive zero
   always_comb begin
      for (int s = 0; s < int'(NUM_SRC); s++) begin
         logic  lane_ok;
         logic  lane_self;
         data_t lane_ext;
         path_e path;

         local_op[s] = fwd_hit[s] ? fwd_data[s] : rf_data[s];
         lane_ok     = int'(sel[s].lane_idx) < int'(NUM_LANES);
         lane_self   = int'(sel[s].lane_idx) == int'(LANE_ID);
         lane_ext    = '0;
         if (lane_ok) begin
            lane_ext = I_Lane_Data[(s*int'(NUM_LANES) + int'(sel[s].lane_idx))*WIDTH_DATA
                                   +: WIDTH_DATA];
         end
         path = decode_path(sel[s].scalar_en, sel[s].lane_en, lane_self);
         unique case (path)
            PathScalar: final_op[s] = I_Scalar_Data;
            PathLane:   final_op[s] = lane_ext;
            PathLoop:   final_op[s] = local_op[s];
            PathLocal:  final_op[s] = local_op[s];
            default:    final_op[s] = local_op[s];
         endcase
         if (!active[s]) begin
            final_op[s] = '0;
            local_op[s] = '0;
         end
      end
   end

   // Output stage loads every unstalled cycle and holds while stalled
   always_comb begin
      valid_d = valid_q;
      src_d   = src_q;
      lane_d  = lane_q;
      if (!I_Stall) begin
         valid_d = I_Req;
         src_d   = final_op;
         lane_d  = local_op;
      end
   end

   // Output stage registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         src_q   <= '0;
         lane_q  <= '0;
      end else begin
         valid_q <= valid_d;
         src_q   <= src_d;
         lane_q  <= lane_d;
      end
   end

   assign O_Valid     = valid_q;
   assign O_Src_Data  = src_q;
   assign O_Lane_Data = lane_q;

endmodule

// File: tb/tb_operand_net_v.sv
// Directed self-checking bench for operand_net_v with default parameters.
module tb_operand_net_v;

   localparam int unsigned NL = 16;
   localparam int unsigned NS = 3;
   localparam int unsigned NR = 4;
   localparam int unsigned WD = 32;
   localparam int unsigned WI = 7;
   localparam int unsigned WF = 8;

   logic                  clock = 1'b0;
   logic                  reset;
   logic                  I_Req;
   logic                  I_Stall;
   logic [NS*WF-1:0]      I_Sel_Path;
   logic [NS-1:0]         I_Sel_ALU_Src;
   logic [WD-1:0]         I_Scalar_Data;
   logic [NR*WD-1:0]      I_Src_Data;
   logic [NR*WI-1:0]      I_Src_Idx;
   logic                  I_WB_Valid;
   logic [WI-1:0]         I_WB_DstIdx;
   logic [WD-1:0]         I_WB_Data;
   logic [NS*NL*WD-1:0]   I_Lane_Data;
   logic                  O_Valid;
   logic [NS*WD-1:0]      O_Src_Data;
   logic [NS*WD-1:0]      O_Lane_Data;

   int n_assert = 0;
   int n_fail   = 0;

   operand_net_v dut (
      .clock         (clock),
      .reset         (reset),
      .I_Req         (I_Req),
      .I_Stall       (I_Stall),
      .I_Sel_Path    (I_Sel_Path),
      .I_Sel_ALU_Src (I_Sel_ALU_Src),
      .I_Scalar_Data (I_Scalar_Data),
      .I_Src_Data    (I_Src_Data),
      .I_Src_Idx     (I_Src_Idx),
      .I_WB_Valid    (I_WB_Valid),
      .I_WB_DstIdx   (I_WB_DstIdx),
      .I_WB_Data     (I_WB_Data),
      .I_Lane_Data   (I_Lane_Data),
      .O_Valid       (O_Valid),
      .O_Src_Data    (O_Src_Data),
      .O_Lane_Data   (O_Lane_Data)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] fld(input int rfp, input bit sc, input bit ln, input int lidx);
      logic [1:0] r;
      logic [3:0] l;
      r = rfp[1:0];
      l = lidx[3:0];
      return {l, ln, sc, r};
   endfunction

   function automatic logic [31:0] osrc(input int s);
      return O_Src_Data[s*WD +: WD];
   endfunction

   function automatic logic [31:0] olane(input int s);
      return O_Lane_Data[s*WD +: WD];
   endfunction

   task automatic set_rf(input int p, input logic [6:0] idx, input logic [31:0] d);
      I_Src_Idx[p*WI +: WI]  = idx;
      I_Src_Data[p*WD +: WD] = d;
   endtask

   task automatic set_sel(input int s, input logic [7:0] f);
      I_Sel_Path[s*WF +: WF] = f;
   endtask

   task automatic set_lane(input int s, input int l, input logic [31:0] d);
      I_Lane_Data[(s*NL + l)*WD +: WD] = d;
   endtask

   task automatic wb(input bit v, input logic [6:0] idx, input logic [31:0] d);
      I_WB_Valid  = v;
      I_WB_DstIdx = idx;
      I_WB_Data   = d;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      I_Req = 1'b0;
      I_Stall = 1'b0;
      I_Sel_Path = '0;
      I_Sel_ALU_Src = '0;
      I_Scalar_Data = '0;
      I_Src_Data = '0;
      I_Src_Idx = '0;
      I_Lane_Data = '0;
      wb(1'b0, 7'd0, 32'h0);
      for (int p = 0; p < int'(NR); p++) set_rf(p, 7'(10 + p), 32'(32'h100 * (p + 1)));

      // Reset state
      tick();
      tick();
      check("rst_valid", {31'b0, O_Valid}, 32'h0);
      check("rst_src0", osrc(0), 32'h0);
      check("rst_src2", osrc(2), 32'h0);
      check("rst_lane0", olane(0), 32'h0);

      // Some activity, then an asynchronous reset mid-run
      reset = 1'b1;
      I_Req = 1'b1;
      I_Sel_ALU_Src = 3'b001;
      set_sel(0, fld(0, 0, 0, 0));
      tick();
      check("pre_rst_valid", {31'b0, O_Valid}, 32'h1);
      check("pre_rst_src0", osrc(0), 32'h100);
      reset = 1'b0;
      #1;
      check("midrun_rst_valid", {31'b0, O_Valid}, 32'h0);
      check("midrun_rst_src0", osrc(0), 32'h0);
      tick();
      reset = 1'b1;

      // 1: src0 reads port 2
      set_sel(0, fld(2, 0, 0, 0));
      set_rf(2, 7'd12, 32'hA5);
      tick();
      check("t1_valid", {31'b0, O_Valid}, 32'h1);
      check("t1_src0", osrc(0), 32'hA5);
      check("t1_src1", osrc(1), 32'h0);
      check("t1_src2", osrc(2), 32'h0);
      check("t1_lane0", olane(0), 32'hA5);

      // 2: two writebacks to idx 5, newest wins
      I_Req = 1'b0;
      wb(1'b1, 7'd5, 32'h11);
      tick();
      wb(1'b1, 7'd5, 32'h22);
      tick();
      wb(1'b0, 7'd0, 32'h0);
      check("t2_noreq_valid", {31'b0, O_Valid}, 32'h0);
      I_Req = 1'b1;
      I_Sel_ALU_Src = 3'b010;
      set_sel(1, fld(1, 0, 0, 0));
      set_rf(1, 7'd5, 32'h0);
      tick();
      check("t2_newest", osrc(1), 32'h22);
      check("t2_src0_inactive", osrc(0), 32'h0);

      // 3: live writeback forwards in the same cycle, ages out after three more
      I_Sel_ALU_Src = 3'b001;
      set_sel(0, fld(3, 0, 0, 0));
      set_rf(3, 7'd9, 32'h99);
      wb(1'b1, 7'd9, 32'h77);
      tick();
      check("t3_live_wb", osrc(0), 32'h77);
      I_Req = 1'b0;
      wb(1'b1, 7'd20, 32'hDEAD);
      tick();
      wb(1'b0, 7'd0, 32'h0);
      I_Req = 1'b1;
      tick();
      check("t3_oldest_entry", osrc(0), 32'h77);
      I_Req = 1'b0;
      wb(1'b1, 7'd21, 32'hDEAD);
      tick();
      wb(1'b1, 7'd22, 32'hDEAD);
      tick();
      wb(1'b0, 7'd0, 32'h0);
      I_Req = 1'b1;
      tick();
      check("t3_aged_out", osrc(0), 32'h99);

      // 4: scalar and lane substitution on src2
      I_Sel_ALU_Src = 3'b100;
      set_rf(0, 7'd10, 32'h1000);
      I_Scalar_Data = 32'h5;
      set_lane(2, 3, 32'h33);
      set_lane(2, 5, 32'h55);
      set_lane(2, 0, 32'hEE);
      set_sel(2, fld(0, 1, 1, 3));
      tick();
      check("t4_scalar", osrc(2), 32'h5);
      check("t4_scalar_lane_local", olane(2), 32'h1000);
      set_sel(2, fld(0, 0, 1, 3));
      tick();
      check("t4_lane3", osrc(2), 32'h33);
      check("t4_lane3_local", olane(2), 32'h1000);
      set_sel(2, fld(0, 0, 1, 5));
      tick();
      check("t4_lane5", osrc(2), 32'h55);
      set_sel(2, fld(0, 0, 1, 0));
      tick();
      check("t4_loopback", osrc(2), 32'h1000);

      // 5: stall holds outputs; writeback during stall shows after release
      I_Sel_ALU_Src = 3'b001;
      set_sel(0, fld(0, 0, 0, 0));
      tick();
      check("t5_pre_stall", osrc(0), 32'h1000);
      I_Stall = 1'b1;
      set_rf(0, 7'd10, 32'h2000);
      wb(1'b1, 7'd10, 32'hBEEF);
      tick();
      wb(1'b0, 7'd0, 32'h0);
      check("t5_stall1", osrc(0), 32'h1000);
      tick();
      check("t5_stall2", osrc(0), 32'h1000);
      tick();
      check("t5_stall3", osrc(0), 32'h1000);
      check("t5_stall3_lane", olane(0), 32'h1000);
      check("t5_stall3_valid", {31'b0, O_Valid}, 32'h1);
      I_Stall = 1'b0;
      tick();
      check("t5_release_fwd", osrc(0), 32'hBEEF);
      check("t5_release_lane", olane(0), 32'hBEEF);

      // 6: no request clears outputs
      I_Req = 1'b0;
      tick();
      check("t6_valid", {31'b0, O_Valid}, 32'h0);
      check("t6_src0", osrc(0), 32'h0);
      check("t6_src1", osrc(1), 32'h0);
      check("t6_src2", osrc(2), 32'h0);
      check("t6_lane0", olane(0), 32'h0);

      // Reset during a stall clears outputs and history
      I_Req = 1'b1;
      tick();
      check("rs_pre", osrc(0), 32'hBEEF);
      I_Stall = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("rs_stall_valid", {31'b0, O_Valid}, 32'h0);
      check("rs_stall_src0", osrc(0), 32'h0);
      tick();
      reset = 1'b1;
      I_Stall = 1'b0;
      tick();
      check("rs_hist_lost", osrc(0), 32'h2000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/operand_net_v.md
Name: operand_net_v

Overview:
Parametrised per-lane operand network for the vector unit. It sits between the lane register file and the execution unit.
- For NUM_SRC ALU sources it selects a register-file read port, applies writeback forwarding from a NUM_WB-deep history, and optionally substitutes scalar broadcast or another lane's operand.
- Results are registered into a stallable output stage.
- Generalises the fixed 3-source, single-writeback network with configurable sources, ports and forwarding depth, plus registered lane export.

Parameters:
NUM_LANES, 16, lanes in the vector unit
LANE_ID, 0, index of this lane
NUM_SRC, 3, ALU source operands
NUM_RFP, 4, register-file read ports
NUM_WB, 2, writeback history depth (>=1)
WIDTH_DATA, 32, operand width
WIDTH_IDX, 7, register index width
WIDTH_LANES, $clog2(NUM_LANES), lane index width
WIDTH_RFP, $clog2(NUM_RFP), read-port select width
WIDTH_F, WIDTH_RFP+2+WIDTH_LANES, per-source select field width

Ports:
clock  in  1  clock
reset  in  1  asynchronous active-low reset
I_Req  in  1  operand request
I_Stall  in  1  execution unit stall; output stage holds
I_Sel_Path  in  NUM_SRC*WIDTH_F  per-source field; LSB first: rfp_sel, scalar_en, lane_en, lane_idx
I_Sel_ALU_Src  in  NUM_SRC  source enables
I_Scalar_Data  in  WIDTH_DATA  scalar broadcast
I_Src_Data  in  NUM_RFP*WIDTH_DATA  register-file read data
I_Src_Idx  in  NUM_RFP*WIDTH_IDX  register-file read indices
I_WB_Valid  in  1  writeback valid
I_WB_DstIdx  in  WIDTH_IDX  writeback index
I_WB_Data  in  WIDTH_DATA  writeback data
I_Lane_Data  in  NUM_SRC*NUM_LANES*WIDTH_DATA  exported operands of all lanes
O_Valid  out  1  operands valid
O_Src_Data  out  NUM_SRC*WIDTH_DATA  operands to the execution unit
O_Lane_Data  out  NUM_SRC*WIDTH_DATA  this lane's local operands exported to other lanes

Behaviour:
Reset:
- Asynchronous, active-low.
- O_Valid, O_Src_Data, O_Lane_Data and all history valid bits clear to 0.

History buffer:
- NUM_WB entries of {valid, idx, data}.
- On I_WB_Valid, the shift-in is {1, I_WB_DstIdx, I_WB_Data} into entry 0; the oldest entry is dropped.
- With I_WB_Valid=0 the buffer does not shift.
- The buffer updates independently of I_Stall.

Combinational path, per source s (active only when I_Req & I_Sel_ALU_Src[s]):
- Raw operand: rf = I_Src_Data[rfp_sel], ridx = I_Src_Idx[rfp_sel].
- Local operand L: forwarded data on an index match, else rf.
- Match priority, newest first: live I_WB (valid & idx==ridx), then entry 0 .. NUM_WB-1.
- Final operand priority: scalar_en gives I_Scalar_Data; else lane_en gives I_Lane_Data[s][lane_idx]; else L.
- lane_en with lane_idx==LANE_ID yields L (loopback, not the external copy).
- Inactive source: final = 0 and L = 0.

Output stage:
- Latency is 1 cycle.
- When I_Stall=0, each clock loads O_Valid<=I_Req, O_Src_Data<=final and O_Lane_Data<=L.
- When I_Stall=1, all three hold.
- Upstream holds I_Req and its operands during a stall. The network does not capture input while stalled.
- Forwarding is re-evaluated each cycle, so a writeback that arrives during a stall is reflected when the stall releases.

Boundary cases:
- Duplicate index in the history: the newest entry wins.
- lane_idx >= NUM_LANES: the operand is 0.
- Reset asserted mid-stall clears everything immediately. History is lost; the register file is the source of truth.

Decomposition:
- pkg_tpu additions:
  - data_t/index_t sized by WIDTH_DATA/WIDTH_IDX.
  - netv_sel_t packed struct {lane_idx, lane_en, scalar_en, rfp_sel}.
  - wb_hist_t {valid, idx, data}.
- One sub-module, fwd_hist_v:
  - Owns the NUM_WB history shift register.
  - Given a query index, returns {hit, data} with newest-first priority, live WB included.
  - Instantiated NUM_SRC times for lookup, or once with NUM_SRC query ports.

Test Plan:
1. Reset mid-run, then Req, src0 rfp_sel=2, I_Src_Data[2]=0xA5 -> the next cycle gives O_Valid=1 and O_Src_Data[0]=0xA5, with other sources 0.
2. WB idx 5 data 0x11, then WB idx 5 data 0x22; Req with src1 reading idx 5 (RF stale 0x00) -> O_Src_Data[1]=0x22 (newest wins).
3. Live WB idx 9 data 0x77 in the same cycle as Req reading idx 9 -> O_Src_Data=0x77. After NUM_WB+1 other writebacks, the same read returns RF data.
4. src2 scalar_en=1 and lane_en=1, scalar 0x5 -> 0x5. Then lane_en only, lane_idx=3, I_Lane_Data[2][3]=0x33 -> 0x33. lane_idx=LANE_ID -> local L.
5. I_Stall=1 for 3 cycles while the RF data changes -> outputs stay constant. A writeback during the stall appears in the output one cycle after release.
6. I_Req=0 -> O_Valid=0, all O_Src_Data=0, O_Lane_Data=0.
